cn_arbiter: RTL and testbench

//  Completer-node (CN) side arbiter and APB phase sequencer for the crossbar interconnect.

---
 rtl/apb_icn_pkg.sv | 28 ++
 rtl/cn_arbiter_rr_arbiter.sv | 37 +++
 rtl/cn_arbiter.sv | 132 +++++++++++++
 tb/tb_cn_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_icn_pkg.sv
// rtl/apb_icn_pkg.sv - shared types and helpers for the CN arbiter
package apb_icn_pkg;

    // Completer-node phase sequence
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } cn_state_e;

    localparam int NUM_RN_DEF = 4;
    localparam int MAX_RN     = 32;
    localparam int MAX_IDX_W  = 5;

    // Binary index of a one-hot vector; returns 0 for an all-zero vector
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_RN-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_RN; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cn_arbiter_rr_arbiter.sv
// rtl/cn_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
    import apb_icn_pkg::*;
#(
    parameter int NUM_RN = NUM_RN_DEF,
    parameter int IDX_W  = $clog2(NUM_RN)
) (
    input  logic [NUM_RN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_RN-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              any
);

    logic [NUM_RN-1:0] w_gnt;
    logic              w_found;
    logic [IDX_W-1:0]  w_k;

    // Scan upward from ptr with wrap; first set request wins
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_RN; i++) begin
            w_k = IDX_W'((32'(ptr) + 32'(i)) % NUM_RN);
            if (!w_found && req[w_k]) begin
                w_gnt[w_k] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign gnt     = w_gnt;
    assign gnt_idx = IDX_W'(onehot_to_idx(MAX_RN'(w_gnt)));
    assign any     = |req;

endmodule

// File: rtl/cn_arbiter.sv
// rtl/cn_arbiter.sv - CN-side round-robin arbiter and APB phase sequencer
module cn_arbiter
    import apb_icn_pkg::*;
#(
    parameter int NUM_RN  = NUM_RN_DEF,
    parameter int IDX_W   = $clog2(NUM_RN),
    parameter int TIMEOUT = 16,
    parameter int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [NUM_RN-1:0] rn_req,
    output logic [NUM_RN-1:0] cn_ready,
    output logic [NUM_RN-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic              pslverr,
    output logic              rsp_slverr,
    output logic              timeout,
    output logic              busy
);

    // Last ACCESS wait count before completion is forced
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RN - 1);

    cn_state_e         r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [TO_W-1:0]   r_wait_cnt;
    logic [NUM_RN-1:0] r_grant;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [NUM_RN-1:0] r_cn_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_rsp_slverr;
    logic              r_timeout;

    logic [NUM_RN-1:0] w_gnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_any;

    rr_arbiter #(
        .NUM_RN (NUM_RN),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req     (rn_req),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // Phase sequencer; every output is registered here so the crossbar sees clean levels
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_wait_cnt   <= '0;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_cn_ready   <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rsp_slverr <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cn_ready <= '0;
                    r_timeout  <= 1'b0;
                    if (w_any) begin
                        r_state     <= SETUP;
                        r_grant     <= w_gnt;
                        r_grant_idx <= w_gnt_idx;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                    end
                end
                SETUP: begin
                    r_state    <= ACCESS;
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                end
                ACCESS: begin
                    if (pready) begin
                        // A real response always beats a simultaneous timeout
                        r_state      <= DONE;
                        r_rsp_slverr <= pslverr;
                        r_timeout    <= 1'b0;
                        r_cn_ready   <= r_grant;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                    end else if (TIMEOUT != 0 && r_wait_cnt == TO_LAST) begin
                        r_state      <= DONE;
                        r_rsp_slverr <= 1'b1;
                        r_timeout    <= 1'b1;
                        r_cn_ready   <= r_grant;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                    end else if (r_wait_cnt != {TO_W{1'b1}}) begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
                    end
                end
                DONE: begin
                    // Winner drops to lowest priority for the next arbitration
                    r_state      <= IDLE;
                    r_cn_ready   <= '0;
                    r_timeout    <= 1'b0;
                    r_rsp_slverr <= 1'b0;
                    r_grant      <= '0;
                    r_grant_idx  <= '0;
                    r_rr_ptr     <= (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + IDX_W'(1);
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cn_ready   = r_cn_ready;
    assign grant      = r_grant;
    assign grant_idx  = r_grant_idx;
    assign psel       = r_psel;
    assign penable    = r_penable;
    assign rsp_slverr = r_rsp_slverr;
    assign timeout    = r_timeout;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_cn_arbiter.sv
// tb/tb_cn_arbiter.sv - self-checking bench for cn_arbiter
module tb_cn_arbiter;

    localparam int N       = 4;
    localparam int IW      = 2;
    localparam int TIMEOUT = 16;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic [N-1:0]  rn_req = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic [N-1:0]  cn_ready;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          psel;
    logic          penable;
    logic          rsp_slverr;
    logic          timeout;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    cn_arbiter #(.NUM_RN(N), .IDX_W(IW), .TIMEOUT(TIMEOUT)) dut (
        .pclk       (pclk),
        .preset     (preset),
        .rn_req     (rn_req),
        .cn_ready   (cn_ready),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .psel       (psel),
        .penable    (penable),
        .pready     (pready),
        .pslverr    (pslverr),
        .rsp_slverr (rsp_slverr),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // Transaction-level model: who holds the completer, how long it has waited,
    // and whether this cycle is the completion cycle
    bit m_active, m_setup, m_done, m_err, m_to;
    int m_winner, m_waits, m_ptr;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            m_active <= 0; m_setup <= 0; m_done <= 0; m_err <= 0; m_to <= 0;
            m_winner <= 0; m_waits <= 0; m_ptr <= 0;
        end else if (m_done) begin
            m_done   <= 0;
            m_active <= 0;
            m_to     <= 0;
            m_ptr    <= (m_winner + 1) % N;
        end else if (!m_active) begin
            if (rn_req != 0) begin
                m_winner <= pick(rn_req, m_ptr);
                m_active <= 1;
                m_setup  <= 1;
            end
        end else if (m_setup) begin
            m_setup <= 0;
            m_waits <= 0;
        end else if (pready) begin
            m_done <= 1; m_err <= pslverr; m_to <= 0;
        end else if (TIMEOUT != 0 && m_waits == TIMEOUT - 1) begin
            m_done <= 1; m_err <= 1; m_to <= 1;
        end else begin
            m_waits <= m_waits + 1;
        end
    end

    // Fairness record of completions
    bit rec_en = 0;
    int rec_idx[$];
    int rec_cyc[$];

    // Per-cycle compare against the model; rsp_slverr only matters with cn_ready
    always @(negedge pclk) begin
        logic [N-1:0]  e_grant, e_rdy;
        logic [IW-1:0] e_idx;
        logic          e_psel, e_pen, e_err, e_to, e_busy, a_err;
        e_grant = m_active ? (N'(1) << m_winner) : '0;
        e_idx   = m_active ? IW'(m_winner) : '0;
        e_rdy   = m_done ? e_grant : '0;
        e_psel  = m_active && !m_done;
        e_pen   = m_active && !m_setup && !m_done;
        e_err   = m_done && m_err;
        e_to    = m_done && m_to;
        e_busy  = m_active;
        a_err   = rsp_slverr && (e_rdy != 0);
        vectors++;
        if ({cn_ready, grant, grant_idx, psel, penable, a_err, timeout, busy} !==
            {e_rdy, e_grant, e_idx, e_psel, e_pen, e_err, e_to, e_busy}) begin
            miscompares++;
            $display("FAIL cycle %0d model: got rdy=%b gnt=%b idx=%0d psel=%b pen=%b err=%b to=%b busy=%b want rdy=%b gnt=%b idx=%0d psel=%b pen=%b err=%b to=%b busy=%b",
                     cyc, cn_ready, grant, grant_idx, psel, penable, a_err, timeout, busy,
                     e_rdy, e_grant, e_idx, e_psel, e_pen, e_err, e_to, e_busy);
        end
        if (rec_en && cn_ready != 0) begin
            for (int i = 0; i < N; i++) if (cn_ready[i]) rec_idx.push_back(i);
            rec_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        #2 preset = 1'b1;
        @(posedge pclk);
        #2 preset = 1'b0;
        tick();
    endtask

    task automatic wait_ready(input string nm, input int bound);
        int n = 0;
        while (cn_ready == 0 && n < bound) begin
            tick();
            n++;
        end
        chk(nm, 32'(cn_ready != 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge pclk);
        #2 preset = 1'b0;
        tick();
        chk("reset_grant", 32'(grant), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_psel", 32'(psel), 0);

        // 1 single request from RN2
        rn_req = 4'b0100; pready = 1'b1;
        tick();
        chk("t1_grant_c1", 32'(grant), 32'h4);
        chk("t1_idx_c1", 32'(grant_idx), 2);
        chk("t1_psel_pen_c1", {30'd0, psel, penable}, 32'b10);
        rn_req = '0;
        tick();
        chk("t1_psel_pen_c2", {30'd0, psel, penable}, 32'b11);
        chk("t1_rdy_c2", 32'(cn_ready), 0);
        tick();
        chk("t1_rdy_c3", 32'(cn_ready), 32'h4);
        chk("t1_grant_c3", 32'(grant), 32'h4);
        chk("t1_err_c3", 32'(rsp_slverr), 0);
        tick();
        chk("t1_rdy_c4", 32'(cn_ready), 0);
        chk("t1_busy_c4", 32'(busy), 0);

        // 2 fairness with all RNs requesting
        do_reset();
        rn_req = 4'b1111; rec_en = 1;
        repeat (20) tick();
        rec_en = 0; rn_req = '0;
        chk("t2_count", 32'(rec_idx.size() >= 5), 1);
        if (rec_idx.size() >= 5) begin
            chk("t2_order0", rec_idx[0], 0);
            chk("t2_order1", rec_idx[1], 1);
            chk("t2_order2", rec_idx[2], 2);
            chk("t2_order3", rec_idx[3], 3);
            chk("t2_order4", rec_idx[4], 0);
            chk("t2_period", rec_cyc[4] - rec_cyc[0], 16);
        end
        repeat (4) tick();

        // 3 completer error passes through
        rn_req = 4'b0001; pready = 1'b1; pslverr = 1'b1;
        tick();
        rn_req = '0;
        wait_ready("t3_ready_seen", 8);
        chk("t3_err", 32'(rsp_slverr), 1);
        chk("t3_to", 32'(timeout), 0);
        pslverr = 1'b0;
        tick();

        // 4a forced completion after 16 waiting ACCESS cycles
        pready = 1'b0; rn_req = 4'b0010;
        tick();
        rn_req = '0;
        tick();
        n = 0;
        while (penable && n < 40) begin
            n++;
            tick();
        end
        chk("t4_access_cycles", n, 16);
        chk("t4_rdy", 32'(cn_ready), 32'h2);
        chk("t4_err", 32'(rsp_slverr), 1);
        chk("t4_to", 32'(timeout), 1);
        tick();
        chk("t4_to_pulse", 32'(timeout), 0);

        // 4b pready arrives on the 16th ACCESS cycle
        rn_req = 4'b0010;
        tick();
        rn_req = '0;
        tick();
        repeat (15) tick();
        chk("t4b_still_access", 32'(penable), 1);
        pready = 1'b1;
        tick();
        chk("t4b_rdy", 32'(cn_ready), 32'h2);
        chk("t4b_to", 32'(timeout), 0);
        chk("t4b_err", 32'(rsp_slverr), 0);
        tick();

        // 5 asynchronous reset during ACCESS
        pready = 1'b0; rn_req = 4'b0100;
        tick();
        rn_req = '0;
        repeat (3) tick();
        #2 preset = 1'b1;
        #1;
        chk("t5_async_zero", {26'd0, psel, penable, grant}, 0);
        chk("t5_async_rdy", 32'(cn_ready), 0);
        @(posedge pclk);
        #2 preset = 1'b0;
        tick();
        rn_req = 4'b1010; pready = 1'b1;
        tick();
        chk("t5_grant_after_reset", 32'(grant), 32'h2);
        rn_req = '0;
        wait_ready("t5_ready_seen", 8);
        tick();

        // 6 RN3 withdraws its request during SETUP
        rn_req = 4'b1000;
        tick();
        chk("t6_grant", 32'(grant), 32'h8);
        rn_req = '0;
        wait_ready("t6_ready_seen", 8);
        chk("t6_rdy", 32'(cn_ready), 32'h8);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
